// File: rtl/traffic_pkg.sv
// Shared lamp encodings and phase codes for the intersection controller and
// the per-road light blocks.
package traffic_pkg;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  typedef enum logic [2:0] {
    HG    = 3'd0,
    HY    = 3'd1,
    AR_HC = 3'd2,
    CG    = 3'd3,
    CY    = 3'd4,
    AR_CH = 3'd5
  } state_e;

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: cleared on a phase change, otherwise counts up and
// holds once it reaches the supplied limit.
module phase_timer #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q >= limit) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: flops take non-blocking assignments so every register samples the
  // pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/intersection_ctrl.sv
// Highway/country-road phase sequencer: highway green by default, country road
// served on a latched request, with yellow and all-red clearance in between.
module intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int HW_MIN_GREEN = 60,
  parameter int CR_MIN_GREEN = 5,
  parameter int CR_MAX_GREEN = 30,
  parameter int YELLOW_T     = 4,
  parameter int ALL_RED_T    = 2,
  parameter int CNT_W        = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_c,
  output logic [2:0] out_h,
  output logic [2:0] out_c,
  output logic       req_pending,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] HW_LIM    = CNT_W'(HW_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] CRMIN_LIM = CNT_W'(CR_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] CRMAX_LIM = CNT_W'(CR_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_LIM     = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LIM    = CNT_W'(ALL_RED_T - 1);

  state_e           state_q;
  state_e           state_d;
  logic             req_q;
  logic             req_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_limit;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state_d != state_q),
    .limit (cnt_limit),
    .count (cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HG;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_limit = '0;
    case (state_q)
      HG: begin
        cnt_limit = HW_LIM;
        if (cnt == HW_LIM && req_q) state_d = HY;
      end
      HY: begin
        cnt_limit = Y_LIM;
        if (cnt == Y_LIM) state_d = AR_HC;
      end
      AR_HC: begin
        cnt_limit = AR_LIM;
        if (cnt == AR_LIM) state_d = CG;
      end
      CG: begin
        cnt_limit = CRMAX_LIM;
        if (cnt == CRMAX_LIM || (cnt >= CRMIN_LIM && !sensor_c)) state_d = CY;
      end
      CY: begin
        cnt_limit = Y_LIM;
        if (cnt == Y_LIM) state_d = AR_CH;
      end
      AR_CH: begin
        cnt_limit = AR_LIM;
        if (cnt == AR_LIM) state_d = HG;
      end
      default: state_d = AR_CH;
    endcase

    // Entering CG consumes the request; outside CG a waiting car re-arms it.
    req_d = req_q;
    if (sensor_c && state_q != CG) req_d = 1'b1;
    if (state_q != CG && state_d == CG) req_d = 1'b0;
  end

  always_comb begin
    out_h = LAMP_RED;
    out_c = LAMP_RED;
    case (state_q)
      HG:      out_h = LAMP_GREEN;
      HY:      out_h = LAMP_YELLOW;
      CG:      out_c = LAMP_GREEN;
      CY:      out_c = LAMP_YELLOW;
      default: ;
    endcase
  end

  assign phase       = state_q;
  assign req_pending = req_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Scoreboard bench for intersection_ctrl: a behavioural model queues the
// expected outputs per cycle; directed scenarios add explicit timing checks.
module tb_intersection_ctrl;

  localparam int HW   = 8;
  localparam int CMIN = 3;
  localparam int CMAX = 6;
  localparam int YT   = 2;
  localparam int ART  = 1;
  localparam int CW   = 7;

  typedef struct packed {
    logic [2:0] h;
    logic [2:0] c;
    logic       req;
    logic [2:0] ph;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sensor_c = 1'b0;
  logic [2:0] out_h;
  logic [2:0] out_c;
  logic       req_pending;
  logic [2:0] phase;

  always #5 clk = ~clk;

  intersection_ctrl #(
    .HW_MIN_GREEN (HW),
    .CR_MIN_GREEN (CMIN),
    .CR_MAX_GREEN (CMAX),
    .YELLOW_T     (YT),
    .ALL_RED_T    (ART),
    .CNT_W        (CW)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .sensor_c    (sensor_c),
    .out_h       (out_h),
    .out_c       (out_c),
    .req_pending (req_pending),
    .phase       (phase)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model, phase codes 0..5 = HG,HY,AR_HC,CG,CY,AR_CH.
  int   m_st  = 0;
  int   m_cnt = 0;
  logic m_req = 1'b0;
  exp_t sb[$];

  function automatic logic [2:0] lamp_h(input int st);
    case (st)
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] lamp_c(input int st);
    case (st)
      3:       return 3'b001;
      4:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic model_step(input logic s, input logic r);
    int   nst;
    logic nreq;
    exp_t e;
    if (r) begin
      m_st  = 0;
      m_cnt = 0;
      m_req = 1'b0;
    end else begin
      case (m_st)
        0:       nst = (m_cnt >= HW - 1 && m_req) ? 1 : 0;
        1:       nst = (m_cnt == YT - 1) ? 2 : 1;
        2:       nst = (m_cnt == ART - 1) ? 3 : 2;
        3:       nst = (m_cnt == CMAX - 1 || (m_cnt >= CMIN - 1 && !s)) ? 4 : 3;
        4:       nst = (m_cnt == YT - 1) ? 5 : 4;
        default: nst = (m_cnt == ART - 1) ? 0 : 5;
      endcase
      if (nst == 3 && m_st != 3)  nreq = 1'b0;
      else if (s && m_st != 3)    nreq = 1'b1;
      else                        nreq = m_req;
      if (nst != m_st)            m_cnt = 0;
      else if (m_st == 0)         m_cnt = (m_cnt + 1 > HW - 1) ? HW - 1 : m_cnt + 1;
      else                        m_cnt = m_cnt + 1;
      m_st  = nst;
      m_req = nreq;
    end
    e.h   = lamp_h(m_st);
    e.c   = lamp_c(m_st);
    e.req = m_req;
    e.ph  = 3'(m_st);
    sb.push_back(e);
  endtask

  // Observed values of the current cycle and phase-run tracking.
  logic [2:0] obs_h, obs_c, obs_ph;
  logic       obs_req;
  int         run_ph = 0;
  int         run_len = 0;
  bit         fresh = 1'b1;
  int         last_len[6];

  task automatic tick(input logic s, input logic r);
    exp_t e;
    @(negedge clk);
    obs_h   = out_h;
    obs_c   = out_c;
    obs_ph  = phase;
    obs_req = req_pending;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("out_h", obs_h, e.h);
      check("out_c", obs_c, e.c);
      check("req_pending", obs_req, e.req);
      check("phase", obs_ph, e.ph);
      check("both_not_red", (obs_h != 3'b100 && obs_c != 3'b100), 0);
      if (fresh) begin
        run_ph  = obs_ph;
        run_len = 1;
        fresh   = 1'b0;
      end else if (int'(obs_ph) == run_ph) begin
        run_len++;
      end else begin
        check("phase_order", obs_ph, (run_ph + 1) % 6);
        case (run_ph)
          0:       check("hg_len_min", run_len >= HW, 1);
          1:       check("hy_len", run_len, YT);
          2:       check("ar_hc_len", run_len, ART);
          3:       check("cg_len_range", run_len >= CMIN && run_len <= CMAX, 1);
          4:       check("cy_len", run_len, YT);
          default: check("ar_ch_len", run_len, ART);
        endcase
        last_len[run_ph] = run_len;
        run_ph  = obs_ph;
        run_len = 1;
      end
    end
    sensor_c = s;
    reset    = r;
    if (r) fresh = 1'b1;
    model_step(s, r);
  endtask

  int t2_ph[18]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5, 0};
  int t2_req[18] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    // Idle: no request keeps the highway green.
    tick(1'b0, 1'b1);
    for (int c = 0; c < 50; c++) begin
      tick(1'b0, 1'b0);
      check("t1_phase", obs_ph, 0);
      check("t1_out_h", obs_h, 3'b001);
      check("t1_req", obs_req, 0);
    end

    // Single-cycle request at cycle 2: full cycle with gap-out.
    tick(1'b0, 1'b1);
    for (int c = 0; c < 18; c++) begin
      tick(c == 2, 1'b0);
      check("t2_phase", obs_ph, t2_ph[c]);
      check("t2_req", obs_req, t2_req[c]);
    end

    // Continuous demand: country maxes out, highway gets exactly its minimum.
    tick(1'b0, 1'b1);
    last_len = '{default: 0};
    for (int c = 0; c < 40; c++) tick(1'b1, 1'b0);
    check("t3_cg_maxout", last_len[3], CMAX);
    check("t3_hg_min", last_len[0], HW);

    // Late request with the highway counter saturated: HY two cycles later.
    tick(1'b0, 1'b1);
    for (int c = 0; c < 23; c++) begin
      tick(c >= 20, 1'b0);
      if (c == 21) begin
        check("t4_req_set", obs_req, 1);
        check("t4_still_hg", obs_ph, 0);
      end
      if (c == 22) check("t4_hy", obs_ph, 1);
    end

    // Reset during CY returns straight to HG.
    tick(1'b0, 1'b1);
    for (int c = 0; c < 100; c++) begin
      tick(1'b1, 1'b0);
      if (obs_ph == 3'd4) break;
    end
    check("t5_reach_cy", obs_ph, 4);
    tick(1'b1, 1'b1);
    check("t5_cy_at_reset", obs_ph, 4);
    check("t5_req_before", obs_req, 1);
    tick(1'b0, 1'b0);
    check("t5_phase", obs_ph, 0);
    check("t5_out_h", obs_h, 3'b001);
    check("t5_out_c", obs_c, 3'b100);
    check("t5_req", obs_req, 0);
    check("t5_cnt", u_dut.cnt, 0);

    // Random sensor traffic.
    for (int c = 0; c < 10000; c++) tick(1'($urandom_range(0, 1)), 1'b0);
    tick(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
